// File: rtl/reset_ctrl_pkg.sv
// Shared types for the reset-source front end:
// FSM states and cause-bit layout.
package reset_ctrl_pkg;

  typedef enum logic [1:0] {
    ARMED,
    TRIGGER,
    WAIT_BUSY,
    WAIT_DONE
  } rst_state_e;

  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_W   = 3;

  function automatic logic [CAUSE_W-1:0] cause_mask(
    input logic btn,
    input logic wdt,
    input logic sw
  );
    logic [CAUSE_W-1:0] m;
    m            = '0;
    m[CAUSE_BTN] = btn;
    m[CAUSE_WDT] = wdt;
    m[CAUSE_SW]  = sw;
    return m;
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// Push-button synchroniser and debounce counter;
// emits a single press event per held press.
module reset_debounce #(
  parameter int DEBOUNCECYCLES = 50000
) (
  input  logic sys_clk,
  input  logic async_rst_n,
  input  logic clk_en,
  input  logic button_n,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCECYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCECYCLES);
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCECYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          btn_low;

  assign btn_low = ~sync_q[1];

  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else if (clk_en) begin
      sync_q <= {sync_q[0], button_n};
      if (!btn_low) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Fires only on the step into saturation, so a held
  // button cannot retrigger until it is released.
  assign press_evt = btn_low && (cnt_q == CNT_ARM);

endmodule

// File: rtl/reset_source_ctrl.sv
// Reset-source front end: button/watchdog/software -> one trigger.
// Define RESET_CAUSE_LOG_EN for a sticky cause log that survives reset.
module reset_source_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCECYCLES    = 50000,
  parameter int WDTCYCLES         = 2500000,
  parameter int BUSYTIMEOUTCYCLES = 4096
) (
  input  logic         sys_clk,
  input  logic         async_rst_n,
  input  logic         clk_en,
  input  logic         button_n,
  input  logic         wdt_en,
  input  logic         wdt_kick,
  input  logic         sw_rst_req,
  input  logic         rst_busy,
  input  logic         cause_clr,
  output logic         sync_rst_trigger,
  output logic [2:0]   rst_cause,
  output logic         lockout,
  output logic         busy_timeout
);

  localparam int WW = $clog2(WDTCYCLES + 1);
  localparam int BW = $clog2(BUSYTIMEOUTCYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST  = WW'(WDTCYCLES - 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSYTIMEOUTCYCLES - 1);

  rst_state_e   state_q;
  rst_state_e   state_d;
  logic         btn_evt;
  logic         wdt_evt_q;
  logic         sw_q;
  logic         sw_q2;
  logic         sw_evt;
  logic [WW-1:0] wdt_cnt_q;
  logic [BW-1:0] busy_cnt_q;
  logic [2:0]   evt_mask;
  logic [2:0]   cause_d;
  logic         req;
  logic         armed;
  logic         load;
  logic         timeout_hit;
  logic         busy_to_q;

  reset_debounce #(
    .DEBOUNCECYCLES(DEBOUNCECYCLES)
  ) u_debounce (
    .sys_clk    (sys_clk),
    .async_rst_n(async_rst_n),
    .clk_en     (clk_en),
    .button_n   (button_n),
    .press_evt  (btn_evt)
  );

  assign armed       = (state_q == ARMED);
  assign sw_evt      = sw_q & ~sw_q2;
  assign evt_mask    = cause_mask(btn_evt, wdt_evt_q, sw_evt);
  assign req         = |evt_mask;
  assign load        = armed & req;
  assign timeout_hit = (state_q == WAIT_BUSY) & ~rst_busy
                     & (busy_cnt_q == BUSY_LAST);

  // Watchdog sits at zero whenever a reset is in flight.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sw_q      <= 1'b0;
      sw_q2     <= 1'b0;
      wdt_cnt_q <= '0;
      wdt_evt_q <= 1'b0;
    end else if (clk_en) begin
      sw_q      <= sw_rst_req;
      sw_q2     <= sw_q;
      wdt_evt_q <= 1'b0;
      if (!wdt_en || wdt_kick || !armed) begin
        wdt_cnt_q <= '0;
      end else if (wdt_cnt_q == WDT_LAST) begin
        wdt_cnt_q <= '0;
        wdt_evt_q <= 1'b1;
      end else begin
        wdt_cnt_q <= wdt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      busy_cnt_q <= '0;
      busy_to_q  <= 1'b0;
    end else if (clk_en) begin
      if ((state_q == WAIT_BUSY) && !rst_busy) begin
        busy_cnt_q <= busy_cnt_q + 1'b1;
      end else begin
        busy_cnt_q <= '0;
      end
      if (timeout_hit) begin
        busy_to_q <= 1'b1;
      end else if (cause_clr) begin
        busy_to_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= ARMED;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:     if (req) state_d = TRIGGER;
      TRIGGER:   state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (rst_busy) begin
          state_d = WAIT_DONE;
        end else if (timeout_hit) begin
          state_d = ARMED;
        end
      end
      WAIT_DONE: if (!rst_busy) state_d = ARMED;
      default:   state_d = ARMED;
    endcase
  end

  always_comb begin
    sync_rst_trigger = (state_q == TRIGGER);
    lockout          = !armed;
  end

`ifdef RESET_CAUSE_LOG_EN
  logic [2:0] cause_q = '0;

  always_comb begin
    cause_d = cause_q;
    unique case (1'b1)
      load:                cause_d = cause_q | evt_mask;
      (cause_clr & ~load): cause_d = '0;
      default:             cause_d = cause_q;
    endcase
  end

  // Deliberately outside async_rst_n so the cause of a reset
  // is still readable after that reset completes.
  always_ff @(posedge sys_clk) begin
    if (clk_en) begin
      cause_q <= cause_d;
    end
  end
`else
  logic [2:0] cause_q;

  always_comb begin
    cause_d = cause_q;
    unique case (1'b1)
      load:                cause_d = evt_mask;
      (cause_clr & ~load): cause_d = '0;
      default:             cause_d = cause_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      cause_q <= '0;
    end else if (clk_en) begin
      cause_q <= cause_d;
    end
  end
`endif

  assign rst_cause    = cause_q;
  assign busy_timeout = busy_to_q;

endmodule
